// File: rtl/decode_stage_param.sv
// Instruction decode stage: IF/ID register, 32-entry register file, ID-stage branch/jump resolution.
// Optional macro RF_BYPASS_EN enables register-file write-through on the read ports.
module decode_stage_param #(
  parameter int          XLEN      = 32,
  parameter int          NREGS     = 32,
  parameter logic [31:0] RST_INSTR = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic [31:0]     instrF,
  input  logic [XLEN-1:0] pc_plus4F,
  input  logic            RegWriteW,
  input  logic [4:0]      WriteRegW,
  input  logic [XLEN-1:0] ResultW,
  input  logic [XLEN-1:0] ALUOutM,
  input  logic [1:0]      ForwardAD,
  input  logic [1:0]      ForwardBD,
  input  logic            BranchD,
  input  logic [1:0]      BrOpD,
  input  logic            JumpD,
  output logic [31:0]     instrD,
  output logic [XLEN-1:0] pc_plus4D,
  output logic [1:0]      PCSrcD,
  output logic [XLEN-1:0] RD1D,
  output logic [XLEN-1:0] RD2D,
  output logic [4:0]      RsD,
  output logic [4:0]      RtD,
  output logic [4:0]      RdD,
  output logic [XLEN-1:0] SignImmD,
  output logic [XLEN-1:0] PCBranchD,
  output logic [XLEN-1:0] JumpAdd
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

  localparam logic [1:0] BR_EQ  = 2'b00;
  localparam logic [1:0] BR_NE  = 2'b01;
  localparam logic [1:0] BR_LEZ = 2'b10;
  localparam logic [1:0] BR_GTZ = 2'b11;

  if_id_t          if_id_q;
  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rd1_rf;
  logic [XLEN-1:0] rd2_rf;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            a_zero;
  logic            a_neg;
  logic            taken;
  logic            wr_en;

  // Stall outranks flush so a held instruction is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_id_q.instr    <= RST_INSTR;
      if_id_q.pc_plus4 <= '0;
    end else if (!StallD) begin
      if (FlushD) begin
        if_id_q.instr    <= RST_INSTR;
        if_id_q.pc_plus4 <= '0;
      end else begin
        if_id_q.instr    <= instrF;
        if_id_q.pc_plus4 <= pc_plus4F;
      end
    end
  end

  assign instrD    = if_id_q.instr;
  assign pc_plus4D = if_id_q.pc_plus4;

  assign RsD = instrD[25:21];
  assign RtD = instrD[20:16];
  assign RdD = instrD[15:11];

  assign SignImmD = {{(XLEN-16){instrD[15]}},
                     instrD[15:0]};

  assign PCBranchD = pc_plus4D
                   + {SignImmD[XLEN-3:0], 2'b00};

  assign JumpAdd = {pc_plus4D[XLEN-1:28],
                    instrD[25:0], 2'b00};

  assign wr_en = RegWriteW
               && (WriteRegW != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++)
        rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[WriteRegW] <= ResultW;
    end
  end

  assign rd1_rf = (RsD == 5'd0) ? '0
                                : rf_q[RsD];
  assign rd2_rf = (RtD == 5'd0) ? '0
                                : rf_q[RtD];

`ifdef RF_BYPASS_EN
  logic byp1;
  logic byp2;

  // Gated by rst so reset really reads zero.
  assign byp1 = rst && wr_en
             && (WriteRegW == RsD);
  assign byp2 = rst && wr_en
             && (WriteRegW == RtD);

  assign RD1D = byp1 ? ResultW : rd1_rf;
  assign RD2D = byp2 ? ResultW : rd2_rf;
`else
  assign RD1D = rd1_rf;
  assign RD2D = rd2_rf;
`endif

  always_comb begin
    src_a = RD1D;
    unique case (ForwardAD)
      2'b01:   src_a = ALUOutM;
      2'b10:   src_a = ResultW;
      default: src_a = RD1D;
    endcase
  end

  always_comb begin
    src_b = RD2D;
    unique case (ForwardBD)
      2'b01:   src_b = ALUOutM;
      2'b10:   src_b = ResultW;
      default: src_b = RD2D;
    endcase
  end

  assign a_zero = (src_a == '0);
  assign a_neg  = src_a[XLEN-1];

  always_comb begin
    taken = 1'b0;
    unique case (BrOpD)
      BR_EQ:   taken = (src_a == src_b);
      BR_NE:   taken = (src_a != src_b);
      BR_LEZ:  taken = a_neg || a_zero;
      BR_GTZ:  taken = !a_neg && !a_zero;
      default: taken = 1'b0;
    endcase
  end

  assign PCSrcD = {JumpD, BranchD & taken};

endmodule
